// File: rtl/hdmi_ctrl_pkg.sv
// Shared types and default timing for the HDMI link bring-up sequencer.
// Timing defaults assume the 200 MHz reference clock.
package hdmi_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RST_MMCM  = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_WAIT_HPD  = 2'd2,
    ST_RUN       = 2'd3
  } link_state_e;

  localparam int DEF_MMCM_RST_CYCLES = 64;
  localparam int DEF_LOCK_WAIT       = 200000;
  localparam int DEF_LOCK_TIMEOUT    = 20000000;
  localparam int DEF_HPD_DEBOUNCE    = 2000000;
  localparam int DEF_BTN_DEBOUNCE    = 4000000;
  localparam int DEF_N_PATTERNS      = 4;

  function automatic int sel_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hdmi_link_ctrl_sync_debounce.sv
// Two-flop synchroniser followed by a stability counter; level toggles only
// after the synced input has disagreed with it for STABLE_CYCLES cycles.
module sync_debounce #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;

  always_comb begin
    sync_d  = {sync_q[0], din};
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) level_d = ~level_q;
      else                   cnt_d   = cnt_q + 1'b1;
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/hdmi_link_ctrl.sv
// HDMI TX bring-up/recovery sequencer: pulses the pixel MMCM reset, qualifies
// lock and hot-plug, gates the encoder and TMDS outputs, steps the test pattern.
module hdmi_link_ctrl
  import hdmi_ctrl_pkg::*;
#(
  parameter int MMCM_RST_CYCLES = DEF_MMCM_RST_CYCLES,
  parameter int LOCK_WAIT       = DEF_LOCK_WAIT,
  parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
  parameter int HPD_DEBOUNCE    = DEF_HPD_DEBOUNCE,
  parameter int BTN_DEBOUNCE    = DEF_BTN_DEBOUNCE,
  parameter int N_PATTERNS      = DEF_N_PATTERNS
) (
  input  logic                           clk_200mhz,
  input  logic                           rst,
  input  logic                           mmcm_locked,
  input  logic                           hdmi_hdp,
  input  logic                           btn,
  output logic                           mmcm_rst,
  output logic                           hdmi_rst,
  output logic                           tx_en,
  output logic [sel_w(N_PATTERNS)-1:0]   pattern_sel,
  output logic [1:0]                     state,
  output logic [3:0]                     retry_cnt
);

  localparam int PW  = sel_w(N_PATTERNS);
  localparam int RCW = $clog2(MMCM_RST_CYCLES + 1);
  localparam int LCW = $clog2(LOCK_WAIT + 1);
  localparam int TCW = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [RCW-1:0] RST_LAST  = RCW'(MMCM_RST_CYCLES - 1);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_WAIT - 1);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(LOCK_TIMEOUT - 1);
  localparam logic [PW-1:0]  PAT_LAST  = PW'(N_PATTERNS - 1);

  link_state_e    state_q, state_d;
  logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic [TCW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [3:0]     retry_q, retry_d;
  logic [PW-1:0]  pat_q, pat_d;
  logic [1:0]     lock_sync_q, lock_sync_d;

  logic lock_s;
  logic hpd_level, hpd_rise;
  logic btn_level, btn_rise;
  logic unused_dbg;

  sync_debounce #(.STABLE_CYCLES(HPD_DEBOUNCE)) u_hpd_db (
    .clk(clk_200mhz), .rst(rst), .din(hdmi_hdp), .level(hpd_level), .rise(hpd_rise)
  );

  sync_debounce #(.STABLE_CYCLES(BTN_DEBOUNCE)) u_btn_db (
    .clk(clk_200mhz), .rst(rst), .din(btn), .level(btn_level), .rise(btn_rise)
  );

  assign unused_dbg = hpd_rise ^ btn_level;

  // Lock loss must react immediately, so lock is synchronised but not debounced.
  assign lock_s = lock_sync_q[1];

  always_comb begin
    lock_sync_d = {lock_sync_q[0], mmcm_locked};
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    lock_cnt_d  = lock_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    retry_d     = retry_q;
    pat_d       = pat_q;

    unique case (state_q)
      ST_RST_MMCM: begin
        lock_cnt_d = '0;
        tmo_cnt_d  = '0;
        if (rst_cnt_q == RST_LAST) begin
          rst_cnt_d = '0;
          state_d   = ST_WAIT_LOCK;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        tmo_cnt_d  = tmo_cnt_q + 1'b1;
        lock_cnt_d = lock_s ? lock_cnt_q + 1'b1 : '0;
        // A completed lock qualification beats a simultaneous timeout.
        if (lock_s && lock_cnt_q == LOCK_LAST) begin
          state_d = ST_WAIT_HPD;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = ST_RST_MMCM;
          rst_cnt_d = '0;
          if (retry_q != 4'hF) retry_d = retry_q + 1'b1;
        end
      end
      ST_WAIT_HPD: begin
        if (!lock_s) begin
          state_d   = ST_RST_MMCM;
          rst_cnt_d = '0;
        end else if (hpd_level) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d   = ST_RST_MMCM;
          rst_cnt_d = '0;
        end else if (!hpd_level) begin
          state_d = ST_WAIT_HPD;
        end
      end
    endcase

    if (btn_rise) pat_d = (pat_q == PAT_LAST) ? '0 : pat_q + 1'b1;
  end

  always_ff @(posedge clk_200mhz) begin
    if (rst) begin
      state_q     <= ST_RST_MMCM;
      rst_cnt_q   <= '0;
      lock_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      retry_q     <= '0;
      pat_q       <= '0;
      lock_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      retry_q     <= retry_d;
      pat_q       <= pat_d;
      lock_sync_q <= lock_sync_d;
    end
  end

  always_comb begin
    mmcm_rst = 1'b0;
    hdmi_rst = 1'b1;
    tx_en    = 1'b0;
    unique case (state_q)
      ST_RST_MMCM:              mmcm_rst = 1'b1;
      ST_WAIT_LOCK, ST_WAIT_HPD: hdmi_rst = 1'b1;
      ST_RUN: begin
        hdmi_rst = 1'b0;
        tx_en    = 1'b1;
      end
    endcase
  end

  assign state       = state_q;
  assign retry_cnt   = retry_q;
  assign pattern_sel = pat_q;

endmodule

// File: tb/tb_hdmi_link_ctrl.sv
// Directed bench for hdmi_link_ctrl: expected per-cycle output words are queued
// as stimulus is planned and popped against the DUT one cycle at a time.
module tb_hdmi_link_ctrl;

  localparam int MRC = 4, LW = 8, LT = 50, HD = 16, BD = 16, NP = 3;

  logic       clk_200mhz = 1'b0;
  logic       rst = 1'b1, mmcm_locked = 1'b0, hdmi_hdp = 1'b0, btn = 1'b0;
  logic       mmcm_rst, hdmi_rst, tx_en;
  logic [1:0] pattern_sel, state;
  logic [3:0] retry_cnt;

  always #5 clk_200mhz = ~clk_200mhz;

  hdmi_link_ctrl #(
    .MMCM_RST_CYCLES(MRC), .LOCK_WAIT(LW), .LOCK_TIMEOUT(LT),
    .HPD_DEBOUNCE(HD), .BTN_DEBOUNCE(BD), .N_PATTERNS(NP)
  ) dut (
    .clk_200mhz(clk_200mhz), .rst(rst), .mmcm_locked(mmcm_locked),
    .hdmi_hdp(hdmi_hdp), .btn(btn), .mmcm_rst(mmcm_rst), .hdmi_rst(hdmi_rst),
    .tx_en(tx_en), .pattern_sel(pattern_sel), .state(state), .retry_cnt(retry_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [10:0] exp_q[$];
  string       tag_q[$];

  // Expected word: {state, retry, mmcm_rst, hdmi_rst, tx_en, pattern}
  function automatic logic [10:0] mk(input int st, input int rt, input int pat);
    logic m, h, t;
    m = (st == 0);
    h = (st != 3);
    t = (st == 3);
    return {st[1:0], rt[3:0], m, h, t, pat[1:0]};
  endfunction

  function automatic logic [10:0] obs();
    return {state, retry_cnt, mmcm_rst, hdmi_rst, tx_en, pattern_sel};
  endfunction

  task automatic tick();
    @(posedge clk_200mhz);
    #1;
  endtask

  task automatic push_n(input string tag, input int n, input int st, input int rt, input int pat);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mk(st, rt, pat));
      tag_q.push_back(tag);
    end
  endtask

  task automatic sb_check();
    logic [10:0] e, a;
    string t;
    a = obs();
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL sb_underflow: got 0x%0h with no expectation queued", a);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (a === e) else begin
        n_fail++;
        $error("FAIL %s: got 0x%0h (st=%0d rt=%0d pat=%0d) want 0x%0h", t, a, a[10:9], a[8:5], a[1:0], e);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      sb_check();
    end
  endtask

  // Leaves the bench just after the first edge with rst released pending.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    repeat (3) tick();
    push_n(tag, 1, 0, 0, 0);
    sb_check();
    rst = 1'b0;
  endtask

  task automatic press(input int len);
    btn = 1'b1;
    repeat (len) tick();
    btn = 1'b0;
    repeat (30) tick();
  endtask

  initial begin
    // 1: normal bring-up
    mmcm_locked = 1'b1; hdmi_hdp = 1'b1; btn = 1'b0;
    do_reset("reset_state");
    push_n("bringup_rst", MRC - 1, 0, 0, 0);
    push_n("bringup_lock", LW, 1, 0, 0);
    push_n("bringup_hpd", 7, 2, 0, 0);
    push_n("bringup_run", 2, 3, 0, 0);
    run(MRC - 1 + LW + 7 + 2);

    // 2: lock never arrives, retries saturate
    mmcm_locked = 1'b0;
    do_reset("timeout_reset");
    for (int a = 0; a <= 16; a++) begin
      push_n("timeout_rst", (a == 0) ? MRC - 1 : MRC, 0, (a > 15) ? 15 : a, 0);
      push_n("timeout_wait", LT, 1, (a > 15) ? 15 : a, 0);
    end
    push_n("timeout_sat", 1, 0, 15, 0);
    run(MRC - 1 + LT + 16 * (MRC + LT) + 1);

    // 3: lock chatter restarts qualification
    mmcm_locked = 1'b0; hdmi_hdp = 1'b1;
    do_reset("chatter_reset");
    push_n("chatter_rst", 3, 0, 0, 0);
    run(3);
    mmcm_locked = 1'b1;
    push_n("chatter_hi", 5, 1, 0, 0);
    run(5);
    mmcm_locked = 1'b0;
    push_n("chatter_lo", 1, 1, 0, 0);
    run(1);
    mmcm_locked = 1'b1;
    push_n("chatter_requal", 9, 1, 0, 0);
    push_n("chatter_hpd", 1, 2, 0, 0);
    push_n("chatter_run", 2, 3, 0, 0);
    run(12);

    // 4: HPD glitches (10 and 15 cycles) filtered, real unplug honoured
    hdmi_hdp = 1'b0;
    push_n("hpd_glitch10", 10, 3, 0, 0);
    run(10);
    hdmi_hdp = 1'b1;
    push_n("hpd_glitch10_after", 30, 3, 0, 0);
    run(30);
    hdmi_hdp = 1'b0;
    push_n("hpd_glitch15", 15, 3, 0, 0);
    run(15);
    hdmi_hdp = 1'b1;
    push_n("hpd_glitch15_after", 30, 3, 0, 0);
    run(30);
    hdmi_hdp = 1'b0;
    push_n("unplug_run", 18, 3, 0, 0);
    push_n("unplug_wait", 22, 2, 0, 0);
    run(40);
    hdmi_hdp = 1'b1;
    push_n("replug_wait", 18, 2, 0, 0);
    push_n("replug_run", 2, 3, 0, 0);
    run(20);

    // 5: lock and HPD lost together: lock loss wins
    mmcm_locked = 1'b0; hdmi_hdp = 1'b0;
    push_n("dual_loss_run", 2, 3, 0, 0);
    push_n("dual_loss_rst", MRC, 0, 0, 0);
    run(2 + MRC);

    // 6: button stepping, bounce rejection, reset clears pattern
    mmcm_locked = 1'b1; hdmi_hdp = 1'b1; btn = 1'b0;
    do_reset("btn_reset");
    push_n("btn_bringup", 3, 0, 0, 0);
    push_n("btn_bringup", LW, 1, 0, 0);
    push_n("btn_bringup", 7, 2, 0, 0);
    push_n("btn_bringup", 1, 3, 0, 0);
    run(3 + LW + 7 + 1);
    for (int i = 1; i <= 3; i++) begin
      press(30);
      push_n("btn_press", 1, 3, 0, i % NP);
      sb_check();
    end
    press(5);
    push_n("btn_bounce", 1, 3, 0, 0);
    sb_check();
    press(30);
    push_n("btn_press4", 1, 3, 0, 1);
    sb_check();
    rst = 1'b1;
    tick();
    push_n("rst_mid_run", 1, 0, 0, 0);
    sb_check();
    rst = 1'b0;

    // Press whose debounced edge lands inside the second RST_MMCM window
    mmcm_locked = 1'b0; btn = 1'b0;
    do_reset("btn_rstmmcm_reset");
    repeat (37) tick();
    btn = 1'b1;
    repeat (18) tick();
    push_n("btn_rstmmcm_pre", 1, 0, 1, 0);
    sb_check();
    tick();
    push_n("btn_rstmmcm_inc", 1, 0, 1, 1);
    sb_check();
    btn = 1'b0;

    n_tests++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_leftover: %0d expectations left, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
